// File: rtl/ram_single_ctrl.sv
// Request/response front-end owning every port of a single-port RAM.
// Clears the RAM after each reset, then serves reads/writes with a one-entry registered response.
module ram_single_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_WIDTH:0] init_cnt;
    logic                fire;
    logic                read_fire;
    logic                write_fire;
    logic                sweep_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Readiness is gated by rst_n so nothing is accepted or written while reset is held.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = req_addr;
        ram_data   = req_data;
        fire       = 1'b0;
        read_fire  = 1'b0;
        write_fire = 1'b0;
        sweep_last = 1'b0;
        case (state)
            INIT: begin
                ram_we     = rst_n;
                ram_addr   = init_cnt[ADDR_WIDTH-1:0];
                ram_data   = INIT_VALUE;
                sweep_last = (init_cnt == LAST_ADDR);
                if (sweep_last) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                req_ready  = rst_n && (!rsp_valid || rsp_ready);
                fire       = req_valid && req_ready;
                read_fire  = fire && !req_we;
                write_fire = fire && req_we;
                ram_we     = write_fire;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (sweep_last) begin
                    init_done <= 1'b1;
                end
            end
            // A new read replaces a response being consumed in the same cycle.
            if (read_fire) begin
                rsp_valid <= 1'b1;
                rsp_data  <= ram_q;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_single_ctrl.sv
// Scoreboard bench for ram_single_ctrl with a behavioural single-port RAM attached.
module tb_ram_single_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam logic [DW-1:0] INITV = 8'hA5;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    wire  [DW-1:0] ram_q;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] exp_q [$];
    int            pop_cycles [$];
    int            cycle;
    int            total;
    int            bad;

    ram_single_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .INIT_VALUE(INITV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (ram_we === 1'b1) begin
            mem[ram_addr] <= ram_data;
        end
    end

    assign ram_q = ram_we ? 'z : mem[ram_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycle);
        end
    endtask

    // Monitor: every response handshake pops one expected value from the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            pop_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_rsp: got %0h expected none", rsp_data);
            end else begin
                checkOutput("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the request has fired.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [DW-1:0] expected);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_data  = data;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (req_ready !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL req_timeout: got req_ready=%b expected 1", req_ready);
        end else if (!we) begin
            exp_q.push_back(expected);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic checkSweep();
        for (int i = 0; i < 2**AW; i++) begin
            @(negedge clk);
            checkOutput("sweep_we", 32'(ram_we), 32'd1);
            checkOutput("sweep_addr", 32'(ram_addr), 32'(i));
            checkOutput("sweep_data", 32'(ram_data), 32'hA5);
            checkOutput("sweep_init_done", 32'(init_done), 32'd0);
            checkOutput("sweep_req_ready", 32'(req_ready), 32'd0);
            checkOutput("sweep_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        checkOutput("done_init_done", 32'(init_done), 32'd1);
        checkOutput("done_req_ready", 32'(req_ready), 32'd1);
        checkOutput("done_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int base;
        total     = 0;
        bad       = 0;
        cycle     = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("por_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("por_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("por_init_done", 32'(init_done), 32'd0);
        checkOutput("por_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkSweep();

        for (int a = 0; a < 2**AW; a++) begin
            applyStimulus(1'b0, AW'(a), 8'h00, 8'hA5);
        end

        applyStimulus(1'b1, 3'd5, 8'h3C, 8'h00);
        applyStimulus(1'b0, 3'd5, 8'h00, 8'h3C);
        @(posedge clk);
        #1;

        // Back-pressure: stuck response blocks a pending write.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 3'd2, 8'h00, 8'hA5);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 3'd2;
        req_data  = 8'h77;
        repeat (4) begin
            @(negedge clk);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_data", 32'(rsp_data), 32'hA5);
            checkOutput("bp_ram_we", 32'(ram_we), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", 32'(req_ready), 32'd1);
        checkOutput("bp_release_we", 32'(ram_we), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        applyStimulus(1'b0, 3'd2, 8'h00, 8'h77);
        @(posedge clk);
        #1;

        // Streaming reads, expecting back-to-back responses.
        base = pop_cycles.size();
        applyStimulus(1'b0, 3'd0, 8'h00, 8'hA5);
        applyStimulus(1'b0, 3'd1, 8'h00, 8'hA5);
        applyStimulus(1'b0, 3'd2, 8'h00, 8'h77);
        applyStimulus(1'b0, 3'd3, 8'h00, 8'hA5);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("stream_count", 32'(pop_cycles.size() - base), 32'd4);
        if (pop_cycles.size() - base == 4) begin
            checkOutput("stream_span", 32'(pop_cycles[base+3] - pop_cycles[base]), 32'd3);
        end

        // Reset in RUN with a pending response.
        applyStimulus(1'b1, 3'd7, 8'hFF, 8'h00);
        applyStimulus(1'b0, 3'd7, 8'h00, 8'hFF);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 3'd0, 8'h00, 8'hA5);
        resetPulse();
        checkSweep();
        rsp_ready = 1'b1;
        applyStimulus(1'b0, 3'd7, 8'h00, 8'hA5);
        @(posedge clk);
        #1;

        // Reset in the middle of the sweep.
        resetPulse();
        n = 0;
        @(negedge clk);
        while (ram_addr !== 3'd3 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput("midinit_reach_addr3", 32'(ram_addr), 32'd3);
        resetPulse();
        checkSweep();
        applyStimulus(1'b0, 3'd6, 8'h00, 8'hA5);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ram_single_ctrl.md
# ram_single_ctrl

Request/response front-end that sits directly upstream of the single-port RAM (`ram_single`) and owns all of its ports. After every reset it clears the RAM to a known value by sweeping every address. It then accepts a valid/ready request stream of reads and writes, drives the RAM's `data`/`addr`/`we`, and returns read data on a registered valid/ready response channel with one-cycle latency and full back-pressure.

## Interface
- `DATA_WIDTH`, default 1: data bus width; must match the RAM.
- `ADDR_WIDTH`, default 1: address width; RAM depth is 2**ADDR_WIDTH.
- `INIT_VALUE`, default 0: DATA_WIDTH-bit value written to every word during initialisation.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready` (fire).
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  request address.
- `req_data`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes the response when `rsp_valid && rsp_ready`.
- `rsp_data`  out  DATA_WIDTH  read data.
- `init_done`  out  1  high once the clear sweep has completed.
- `ram_data`  out  DATA_WIDTH  to RAM `data`.
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `ram_we`  out  1  to RAM `we`.
- `ram_q`  in  DATA_WIDTH  from RAM `q`. Valid only while `ram_we=0`; high-Z otherwise.

## Operation
- **FSM states: INIT, RUN.**
- **Reset** (`rst_n=0` at a clock edge):
  - state goes to INIT and the init counter to 0;
  - `rsp_valid`, `rsp_data` and `init_done` go to 0;
  - `req_ready` and `ram_we` are held at 0 while `rst_n=0`.
- **INIT:**
  - `ram_we=1`, `ram_addr`=counter, `ram_data=INIT_VALUE`, `req_ready=0`;
  - the counter increments every cycle;
  - when counter = 2**ADDR_WIDTH-1, the write completes, state goes to RUN and `init_done` is set to 1;
  - the counter is ADDR_WIDTH+1 bits wide, so there is no wrap ambiguity.
- **RUN:**
  - `req_ready = !rsp_valid || rsp_ready`, a single-entry response register with pass-through readiness.
  - Write fire: `ram_we=1`, `ram_addr=req_addr`, `ram_data=req_data`, committed at that edge. No response is generated.
  - Read fire: `ram_we=0`, `ram_addr=req_addr`. At the edge, `rsp_data` is loaded from `ram_q` and `rsp_valid` is set to 1.
  - No fire: `ram_we=0`, `ram_addr=req_addr`, `ram_data=req_data`, `rsp_data` held.
  - Response consumed with no new read fire: `rsp_valid` is cleared.
  - Response consumed and a new read fires in the same cycle: `rsp_valid` stays 1 and `rsp_data` is replaced.
  - `rsp_valid=1 && rsp_ready=0`: `req_ready=0`, and `rsp_data`/`rsp_valid` are held stable. No request of either kind is accepted, so write ordering relative to reads is preserved.
- `ram_we` is asserted only in INIT or on a write fire. `ram_q` is sampled only on a read fire.
- Reset mid-INIT or mid-RUN: any pending response is dropped and the full clear sweep restarts after `rst_n` returns to 1.
- `init_done` stays 1 until the next reset.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `init_done=0`, `ram_we=0` while in reset.
- With `rst_n` deasserted before edge E0, the sweep writes addresses 0..2**ADDR_WIDTH-1 on edges E0..E(2**ADDR_WIDTH-1).
- `init_done` and `req_ready` are first 1 in the cycle after the last sweep edge.
- Read latency: a read fired at edge N gives `rsp_valid=1` after edge N, with data as of the RAM contents before edge N.
- Write visibility: a write fired at edge N is returned by a read fired at edge N+1 or later.
- Throughput: one request per cycle while `rsp_ready=1`.
- Combinational paths:
  - `rsp_ready` → `req_ready` → `ram_we`;
  - `req_*` → `ram_*`;
  - no `ram_q` → output combinational path.

## Test plan
- **Init sweep.** ADDR_WIDTH=3, INIT_VALUE=8'hA5, DATA_WIDTH=8. Release reset. Expect `ram_we=1` for exactly 8 cycles at addresses 0..7, then `init_done=1` and `req_ready=1`. Reads of 0..7 then return A5.
- **Write then read.** Write 8'h3C to addr 5. Read addr 5 on the next cycle. Expect `rsp_valid=1` one cycle later with `rsp_data=3C`.
- **Back-pressure.** Hold `rsp_ready=0` and issue a read of addr 2. Expect `rsp_valid` held and `req_ready=0` with a write to addr 2 pending for 4 cycles, `rsp_data` stable. Release: the old data is consumed first, then the write commits.
- **Streaming reads.** With `rsp_ready=1`, fire reads of addrs 0,1,2,3 on consecutive cycles. Expect 4 consecutive responses in order with no bubbles.
- **Reset mid-operation.** Pull `rst_n=0` for 1 cycle during RUN after writing 8'hFF to addr 7. Expect `rsp_valid=0` and `init_done=0`, a repeated 8-cycle sweep, and a subsequent read of addr 7 returning A5.
- **Reset mid-INIT.** Assert reset at sweep address 3. Expect the sweep to restart at address 0, with `init_done` asserted 8 cycles after release.
